// File: rtl/syn_fifo_pkg.sv
// syn_fifo_pkg: shared sizing helper and threshold legality check for syn_fifo.
package syn_fifo_pkg;

    function automatic int unsigned level_width(input int unsigned asize);
        return asize + 1;
    endfunction

    function automatic bit thresholds_legal(input int unsigned depth,
                                            input int unsigned af_level,
                                            input int unsigned ae_level);
        return (af_level >= 1) && (af_level <= depth) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/syn_fifo_ram.sv
// syn_fifo_ram: DEPTH x DSIZE simple dual-port RAM, one write port, one registered read port.
module syn_fifo_ram
    import syn_fifo_pkg::*;
#(
    parameter int unsigned ASIZE = 4,
    parameter int unsigned DSIZE = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic             i_re,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);
    localparam int unsigned DEPTH = 1 << ASIZE;

    (* ram_style = "block" *) logic [DSIZE-1:0] r_mem [DEPTH];
    logic [DSIZE-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/syn_fifo.sv
// syn_fifo: single-clock FIFO with exact level, almost flags, error pulses and optional FWFT read.
module syn_fifo
    import syn_fifo_pkg::*;
#(
    parameter int unsigned ASIZE    = 4,
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = (1 << ASIZE) - 4,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_winc,
    input  logic [DSIZE-1:0] I_wdata,
    output logic             O_wfull,
    output logic             O_afull,
    input  logic             I_rinc,
    output logic [DSIZE-1:0] O_rdata,
    output logic             O_rempty,
    output logic             O_aempty,
    output logic [ASIZE:0]   O_level,
    output logic             O_ovf,
    output logic             O_udf
);
    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned LW    = level_width(ASIZE);

    if (!thresholds_legal(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_thresholds
        $error("syn_fifo: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
    end

    logic [ASIZE-1:0] r_waddr, r_raddr;
    logic [LW-1:0]    r_level;
    logic             r_full, r_afull, r_empty, r_aempty, r_ovf, r_udf;
    logic [DSIZE-1:0] r_byp;
    logic             r_sel_ram;

    logic             w_wa, w_ra;
    logic [LW-1:0]    w_level_nxt;
    logic             w_ram_re;
    logic [ASIZE-1:0] w_ram_raddr;
    logic [DSIZE-1:0] w_ram_q;

    always_comb begin
        w_wa        = I_winc & ~r_full;
        w_ra        = I_rinc & ~r_empty;
        w_level_nxt = r_level;
        if (w_wa && !w_ra) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_wa && w_ra) begin
            w_level_nxt = r_level - LW'(1);
        end
        // FWFT: head lives in the output stage, so a pop fetches the word after it.
        if (FWFT != 0) begin
            w_ram_raddr = r_raddr + ASIZE'(1);
            w_ram_re    = w_ra && (r_level >= LW'(2));
        end else begin
            w_ram_raddr = r_raddr;
            w_ram_re    = w_ra;
        end
    end

    syn_fifo_ram #(
        .ASIZE (ASIZE),
        .DSIZE (DSIZE)
    ) u_ram (
        .i_clk   (I_clk),
        .i_rst   (I_rst),
        .i_we    (w_wa & ~I_rst),
        .i_waddr (r_waddr),
        .i_wdata (I_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_waddr   <= '0;
            r_raddr   <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_afull   <= 1'b0;
            r_empty   <= 1'b1;
            r_aempty  <= 1'b1;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_byp     <= '0;
            r_sel_ram <= 1'b1;
        end else begin
            if (w_wa) r_waddr <= r_waddr + ASIZE'(1);
            if (w_ra) r_raddr <= r_raddr + ASIZE'(1);
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == LW'(DEPTH));
            r_afull  <= (w_level_nxt >= LW'(AF_LEVEL));
            r_empty  <= (w_level_nxt == '0);
            r_aempty <= (w_level_nxt <= LW'(AE_LEVEL));
            r_ovf    <= I_winc & r_full;
            r_udf    <= I_rinc & r_empty;
            // Incoming word becomes the head directly when nothing else is queued ahead of it.
            if (w_wa && (r_empty || (w_ra && r_level == LW'(1)))) begin
                r_byp     <= I_wdata;
                r_sel_ram <= 1'b0;
            end else if (w_ram_re) begin
                r_sel_ram <= 1'b1;
            end
        end
    end

    assign O_rdata  = ((FWFT != 0) && !r_sel_ram) ? r_byp : w_ram_q;
    assign O_level  = r_level;
    assign O_wfull  = r_full;
    assign O_afull  = r_afull;
    assign O_rempty = r_empty;
    assign O_aempty = r_aempty;
    assign O_ovf    = r_ovf;
    assign O_udf    = r_udf;

endmodule

// File: tb/tb_syn_fifo.sv
// tb_syn_fifo: directed checks of syn_fifo in standard (dut_a) and FWFT (dut_b) modes.
module tb_syn_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_winc = 1'b0, a_rinc = 1'b0;
    logic [7:0] a_wdata = '0, a_rdata;
    logic       a_wfull, a_afull, a_rempty, a_aempty, a_ovf, a_udf;
    logic [4:0] a_level;

    logic       b_winc = 1'b0, b_rinc = 1'b0;
    logic [7:0] b_wdata = '0, b_rdata;
    logic       b_wfull, b_afull, b_rempty, b_aempty, b_ovf, b_udf;
    logic [4:0] b_level;

    int checks = 0;
    int failures = 0;

    syn_fifo #(.ASIZE(4), .DSIZE(8), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)) dut_a (
        .I_clk(clk), .I_rst(rst), .I_winc(a_winc), .I_wdata(a_wdata),
        .O_wfull(a_wfull), .O_afull(a_afull), .I_rinc(a_rinc), .O_rdata(a_rdata),
        .O_rempty(a_rempty), .O_aempty(a_aempty), .O_level(a_level),
        .O_ovf(a_ovf), .O_udf(a_udf)
    );

    syn_fifo #(.ASIZE(4), .DSIZE(8), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)) dut_b (
        .I_clk(clk), .I_rst(rst), .I_winc(b_winc), .I_wdata(b_wdata),
        .O_wfull(b_wfull), .O_afull(b_afull), .I_rinc(b_rinc), .O_rdata(b_rdata),
        .O_rempty(b_rempty), .O_aempty(b_aempty), .O_level(b_level),
        .O_ovf(b_ovf), .O_udf(b_udf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset, then idle
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
        check("a_rst_level", a_level, 0);
        check("a_rst_rempty", a_rempty, 1);
        check("a_rst_aempty", a_aempty, 1);
        check("a_rst_wfull", a_wfull, 0);
        check("a_rst_afull", a_afull, 0);
        check("a_rst_rdata", a_rdata, 8'h00);
        check("a_rst_ovf", a_ovf, 0);
        check("a_rst_udf", a_udf, 0);
        check("b_rst_rempty", b_rempty, 1);
        check("b_rst_rdata", b_rdata, 8'h00);

        // fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            a_winc = 1'b1; a_wdata = 8'(i);
            tick();
            check($sformatf("a_fill_level[%0d]", i), a_level, i + 1);
            check($sformatf("a_fill_aempty[%0d]", i), a_aempty, (i + 1 <= 2) ? 1 : 0);
            check($sformatf("a_fill_afull[%0d]", i), a_afull, (i + 1 >= 12) ? 1 : 0);
            check($sformatf("a_fill_wfull[%0d]", i), a_wfull, (i == 15) ? 1 : 0);
            check($sformatf("a_fill_rempty[%0d]", i), a_rempty, 0);
        end
        a_wdata = 8'hEE; tick(); a_winc = 1'b0;
        check("a_ovf_pulse", a_ovf, 1);
        check("a_ovf_level", a_level, 16);
        tick();
        check("a_ovf_single", a_ovf, 0);

        // drain 16 in standard mode, then an underflow
        for (int i = 0; i < 16; i++) begin
            a_rinc = 1'b1;
            tick();
            check($sformatf("a_drain_rdata[%0d]", i), a_rdata, i);
            check($sformatf("a_drain_level[%0d]", i), a_level, 15 - i);
        end
        check("a_drain_rempty", a_rempty, 1);
        tick(); a_rinc = 1'b0;
        check("a_udf_pulse", a_udf, 1);
        check("a_udf_rdata", a_rdata, 8'h0F);
        check("a_udf_level", a_level, 0);
        tick();
        check("a_udf_single", a_udf, 0);
        check("a_udf_hold", a_rdata, 8'h0F);

        // level 5, then 40 cycles of simultaneous read/write across wrap
        for (int i = 0; i < 5; i++) begin
            a_winc = 1'b1; a_wdata = 8'(8'h40 + i); tick();
        end
        check("a_lvl5", a_level, 5);
        a_rinc = 1'b1;
        for (int k = 0; k < 40; k++) begin
            a_wdata = 8'(8'h45 + k);
            tick();
            check($sformatf("a_rw_level[%0d]", k), a_level, 5);
            check($sformatf("a_rw_rdata[%0d]", k), a_rdata, 8'h40 + k);
        end
        a_winc = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("a_tail_rdata[%0d]", k), a_rdata, 8'h68 + k);
        end
        check("a_tail_empty", a_rempty, 1);

        // read+write while empty: read rejected, write accepted
        a_winc = 1'b1; a_wdata = 8'h77; tick();
        check("a_empty_rw_udf", a_udf, 1);
        check("a_empty_rw_level", a_level, 1);
        check("a_empty_rw_rdata", a_rdata, 8'h6C);
        a_rinc = 1'b0;
        for (int i = 0; i < 15; i++) begin
            a_wdata = 8'(8'h78 + i); tick();
        end
        check("a_refull", a_wfull, 1);

        // read+write while full: write rejected, read accepted
        a_rinc = 1'b1; a_wdata = 8'h90; tick();
        check("a_full_rw_ovf", a_ovf, 1);
        check("a_full_rw_level", a_level, 15);
        check("a_full_rw_rdata", a_rdata, 8'h77);
        check("a_full_rw_wfull", a_wfull, 0);
        a_rinc = 1'b0; a_wdata = 8'h91; tick();
        check("a_refull2", a_level, 16);

        // reset while full with a write pending: no ovf, everything discarded
        rst = 1'b1; a_wdata = 8'h99; tick();
        rst = 1'b0; a_winc = 1'b0;
        check("a_mrst_level", a_level, 0);
        check("a_mrst_rempty", a_rempty, 1);
        check("a_mrst_ovf", a_ovf, 0);
        check("a_mrst_wfull", a_wfull, 0);
        check("a_mrst_rdata", a_rdata, 8'h00);
        a_winc = 1'b1;
        a_wdata = 8'h11; tick();
        a_wdata = 8'h22; tick();
        a_wdata = 8'h33; tick();
        a_winc = 1'b0; a_rinc = 1'b1;
        tick(); check("a_post_rst_rd0", a_rdata, 8'h11);
        tick(); check("a_post_rst_rd1", a_rdata, 8'h22);
        tick(); check("a_post_rst_rd2", a_rdata, 8'h33);
        a_rinc = 1'b0;

        // FWFT: write into empty presents the word next cycle
        b_winc = 1'b1; b_wdata = 8'hA5; tick(); b_winc = 1'b0;
        check("b_fwft_rdata", b_rdata, 8'hA5);
        check("b_fwft_rempty", b_rempty, 0);
        check("b_fwft_level", b_level, 1);
        tick();
        check("b_fwft_hold", b_rdata, 8'hA5);
        b_rinc = 1'b1; tick(); b_rinc = 1'b0;
        check("b_pop_rempty", b_rempty, 1);
        check("b_pop_level", b_level, 0);

        // FWFT stream: head comes from RAM after each pop
        b_winc = 1'b1;
        b_wdata = 8'h10; tick();
        b_wdata = 8'h11; tick();
        b_wdata = 8'h12; tick();
        b_winc = 1'b0;
        check("b_s_head0", b_rdata, 8'h10);
        check("b_s_level", b_level, 3);
        b_rinc = 1'b1;
        tick(); check("b_s_head1", b_rdata, 8'h11);
        tick(); check("b_s_head2", b_rdata, 8'h12);
        tick(); check("b_s_empty", b_rempty, 1);
        b_rinc = 1'b0;

        // FWFT pop and write at level 1: new word bypasses straight to head
        b_winc = 1'b1; b_wdata = 8'h20; tick();
        b_rinc = 1'b1; b_wdata = 8'h21; tick();
        check("b_byp_rdata", b_rdata, 8'h21);
        check("b_byp_level", b_level, 1);
        b_winc = 1'b0; tick(); b_rinc = 1'b0;
        check("b_byp_empty", b_rempty, 1);

        // FWFT sustained flow at level 3 across wrap
        b_winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_wdata = 8'(8'h50 + i); tick();
        end
        check("b_flow_head", b_rdata, 8'h50);
        b_rinc = 1'b1;
        for (int k = 0; k < 20; k++) begin
            b_wdata = 8'(8'h53 + k);
            tick();
            check($sformatf("b_flow_rdata[%0d]", k), b_rdata, 8'h51 + k);
            check($sformatf("b_flow_level[%0d]", k), b_level, 3);
        end
        b_rinc = 1'b0;

        // fill to level 9, reset with a write pending
        for (int i = 0; i < 6; i++) begin
            b_wdata = 8'(8'h80 + i); tick();
        end
        check("b_lvl9", b_level, 9);
        rst = 1'b1; b_wdata = 8'hEE; tick();
        rst = 1'b0; b_winc = 1'b0;
        check("b_mrst_level", b_level, 0);
        check("b_mrst_rempty", b_rempty, 1);
        check("b_mrst_ovf", b_ovf, 0);
        b_winc = 1'b1;
        b_wdata = 8'hC1; tick();
        check("b_post_rst_head", b_rdata, 8'hC1);
        b_wdata = 8'hC2; tick(); b_winc = 1'b0;
        check("b_post_rst_level", b_level, 2);
        b_rinc = 1'b1; tick(); b_rinc = 1'b0;
        check("b_post_rst_head2", b_rdata, 8'hC2);
        check("b_post_rst_level2", b_level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
